// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle wide adder, one N-bit lookahead slice per clock, LSB chunk first

module cla_seq_adder #(
  parameter int N      = 4,
  parameter int CHUNKS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*CHUNKS-1:0]   a,
  input  logic [N*CHUNKS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [N*CHUNKS-1:0]   sum,
  output logic                  cout
);

  localparam int W  = N * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [N-1:0]    slice_a, slice_b, slice_g, slice_p, slice_sum;
  logic [N:0]      slice_c;
  int              base;

  // Current slice: generate/propagate and carries flattened from the carry register
  always_comb begin
    logic acc;
    logic pp;
    base    = int'(idx_q) * N;
    slice_a = a_q[base +: N];
    slice_b = b_q[base +: N];
    slice_g = slice_a & slice_b;
    slice_p = slice_a ^ slice_b;
    slice_c = '0;
    slice_c[0] = carry_q;
    for (int k = 0; k < N; k++) begin
      acc = slice_g[k];
      pp  = slice_p[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (pp & slice_g[j]);
        pp  = pp & slice_p[j];
      end
      slice_c[k+1] = acc | (pp & carry_q);
    end
    slice_sum = slice_p ^ slice_c[N-1:0];
  end

  // Next-state and registered-output logic; IDLE and DONE both accept start
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: N] = slice_sum;
        carry_d          = slice_c[N];
        idx_d            = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_c[N];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset that abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - directed self-checking bench for cla_seq_adder

module tb_cla_seq_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // dut0: N=4, CHUNKS=2
  logic        start0 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0;
  logic        cin0 = 1'b0;
  logic        busy0, done0, cout0;
  logic [7:0]  sum0;

  // dut1: N=4, CHUNKS=4
  logic        start1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        cin1 = 1'b0;
  logic        busy1, done1, cout1;
  logic [15:0] sum1;

  // dut2: N=8, CHUNKS=1
  logic        start2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        cin2 = 1'b0;
  logic        busy2, done2, cout2;
  logic [7:0]  sum2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.N(4), .CHUNKS(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0)
  );

  cla_seq_adder #(.N(4), .CHUNKS(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  cla_seq_adder #(.N(8), .CHUNKS(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation on dut0 with a changing-operand check after the start edge
  task automatic run0(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input logic vc, input logic [7:0] es, input logic ec);
    start0 = 1'b1; a0 = va; b0 = vb; cin0 = vc;
    tick();
    start0 = 1'b0; a0 = 8'h55; b0 = 8'hAA; cin0 = ~vc;
    chk({tag, "_busy_e0"}, 32'(busy0), 32'd1);
    chk({tag, "_done_e0"}, 32'(done0), 32'd0);
    tick();
    chk({tag, "_busy_e1"}, 32'(busy0), 32'd1);
    chk({tag, "_done_e1"}, 32'(done0), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done0), 32'd1);
    chk({tag, "_busy_dn"}, 32'(busy0), 32'd0);
    chk({tag, "_sum"}, 32'(sum0), 32'(es));
    chk({tag, "_cout"}, 32'(cout0), 32'(ec));
    tick();
    chk({tag, "_done_pulse"}, 32'(done0), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_sum",  32'(sum0),  32'd0);
    chk("rst_cout", 32'(cout0), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);

    // Basic add with carry out, then carry across the chunk boundary
    run0("t1", 8'hBE, 8'h91, 1'b0, 8'h4F, 1'b1);
    run0("t2", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);

    // Back-to-back with start held high; second op accepted in the DONE cycle
    start0 = 1'b1; a0 = 8'h0E; b0 = 8'h01; cin0 = 1'b0;
    tick();
    tick();
    tick();
    chk("b2b1_done", 32'(done0), 32'd1);
    chk("b2b1_sum",  32'(sum0),  32'h0F);
    chk("b2b1_cout", 32'(cout0), 32'd0);
    a0 = 8'h08; b0 = 8'h0F;
    tick();
    start0 = 1'b0;
    chk("b2b2_busy", 32'(busy0), 32'd1);
    chk("b2b2_done", 32'(done0), 32'd0);
    tick();
    tick();
    chk("b2b2_done_f", 32'(done0), 32'd1);
    chk("b2b2_sum",  32'(sum0),  32'h17);
    chk("b2b2_cout", 32'(cout0), 32'd0);
    tick();

    // Reset on the first RUN edge abandons the operation
    start0 = 1'b1; a0 = 8'hB9; b0 = 8'h15; cin0 = 1'b0;
    tick();
    start0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy0), 32'd0);
    chk("mrst_done", 32'(done0), 32'd0);
    chk("mrst_sum",  32'(sum0),  32'd0);
    chk("mrst_cout", 32'(cout0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_nodone", 32'(done0), 32'd0);
    end
    run0("t5", 8'h01, 8'h05, 1'b0, 8'h06, 1'b0);

    // CHUNKS=4: carry ripples through all four slices; start while busy ignored
    start1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0000; cin1 = 1'b1;
    tick();
    a1 = 16'h0001; b1 = 16'h0001; cin1 = 1'b0;
    chk("c4_busy_e0", 32'(busy1), 32'd1);
    tick();
    start1 = 1'b0;
    chk("c4_busy_e1", 32'(busy1), 32'd1);
    tick();
    chk("c4_done_e2", 32'(done1), 32'd0);
    tick();
    chk("c4_busy_e3", 32'(busy1), 32'd1);
    chk("c4_done_e3", 32'(done1), 32'd0);
    tick();
    chk("c4_done", 32'(done1), 32'd1);
    chk("c4_sum",  32'(sum1),  32'h0000);
    chk("c4_cout", 32'(cout1), 32'd1);
    tick();
    chk("c4_idle_busy", 32'(busy1), 32'd0);
    chk("c4_idle_done", 32'(done1), 32'd0);
    chk("c4_hold_sum",  32'(sum1),  32'h0000);
    chk("c4_hold_cout", 32'(cout1), 32'd1);

    // CHUNKS=1: registered single-slice CLA
    start2 = 1'b1; a2 = 8'hFF; b2 = 8'h01; cin2 = 1'b0;
    tick();
    start2 = 1'b0;
    chk("c1_busy", 32'(busy2), 32'd1);
    chk("c1_done_e0", 32'(done2), 32'd0);
    tick();
    chk("c1_done", 32'(done2), 32'd1);
    chk("c1_sum",  32'(sum2),  32'h00);
    chk("c1_cout", 32'(cout2), 32'd1);
    tick();
    chk("c1_pulse", 32'(done2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
Multi-cycle wide adder that adds two W = N*CHUNKS bit operands with carry-in, one N-bit carry-lookahead slice per clock, least-significant chunk first. The inter-chunk carry is registered. It sits upstream of the wide-datapath logic and reuses the n-bit lookahead slice structure of the existing combinational CLA. It trades latency for area when operands exceed a single-cycle CLA width.

Parameters:
N, 4, width of one lookahead slice in bits (N >= 1).
CHUNKS, 2, number of slices per operation (CHUNKS >= 1); W = N*CHUNKS.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  request; sampled on rising clk edge.
a  input  W  operand A; sampled with start.
b  input  W  operand B; sampled with start.
cin  input  1  carry-in to chunk 0; sampled with start.
busy  output  1  high while a computation is in progress.
done  output  1  one-cycle pulse; sum/cout valid.
sum  output  W  result, a+b+cin mod 2^W.
cout  output  1  carry out of the MSB of chunk CHUNKS-1.

Behaviour:
- Reset: rst sampled high on an edge sets state IDLE, busy=0, done=0, sum=0, cout=0, and clears the chunk index and internal carry. This takes priority over everything, including an operation in progress, which is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b and cin into internal operand registers.
  - Sets the chunk index to 0 and the carry register to cin.
  - Goes to RUN with busy=1.
  - start=0 stays in IDLE.
- RUN:
  - Each edge computes chunk i = bits [i*N +: N].
  - Per bit: g = a&b, p = a^b. Carries are lookahead-expanded from the carry register: c0 = carry, c(k+1) = g(k) | p(k)&c(k), flattened per slice.
  - Slice sum = p ^ c.
  - The slice sum is written into sum[i*N +: N], the carry register is set to c(N), and i increments.
  - On the edge that processes i = CHUNKS-1: cout gets c(N), the next state is DONE, busy=0, done=1.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start=1 in this cycle is accepted exactly as in IDLE, with no bubble.
- Timing and handshake:
  - Latency: done is high in the cycle following the CHUNKS-th edge after the edge that sampled start.
  - Throughput: one operation per CHUNKS+1 cycles.
  - start while busy=1 is ignored. Operands are not resampled.
  - a, b and cin may change freely after the start edge, since the operands are held internally.
- Output hold and visibility:
  - sum and cout hold their last result until the next operation writes them.
  - sum is updated chunk-by-chunk during RUN. Upper chunks hold the previous result until overwritten, so sum is only defined as valid when done=1.
  - cout changes only on the final chunk edge.
- CHUNKS=1: a single RUN edge, then DONE. This is equivalent to a registered N-bit CLA with carry-in.
- Wrap-around: the sum is modulo 2^W. Overflow is reported only via cout; signed overflow is not flagged.

Test Plan:
- N=4, CHUNKS=2; start with a=0xBE, b=0x91, cin=0 -> busy=1 for 2 cycles, then done=1 for one cycle with sum=0x4F, cout=1.
- N=4, CHUNKS=2; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0. The carry propagates across the chunk boundary through the carry register.
- N=4, CHUNKS=4; a=0xFFFF, b=0x0000, cin=1 -> done 4 edges after start, sum=0x0000, cout=1. A second start while busy (a=0x0001, b=0x0001) is ignored and the result is unchanged.
- Back-to-back: start held high; first a=0x0E, b=0x01 -> sum=0x0F, cout=0. Then a=0x08, b=0x0F, re-driven in the DONE cycle, is accepted immediately -> sum=0x17, cout=0. No idle bubble between the two operations.
- Reset mid-operation: start a=0xB9, b=0x15, assert rst on the first RUN edge -> next cycle busy=0, done=0, sum=0, cout=0. No done pulse follows. A subsequent start a=0x01, b=0x05 -> sum=0x06, cout=0.
- N=8, CHUNKS=1; a=0xFF, b=0x01, cin=0 -> done on the cycle after the first edge, sum=0x00, cout=1.
